// File: rtl/pattern_dac_gen_if.sv
// Control/config and output signals of the pattern DAC generator, grouped for
// connection between the register block (master) and the generator (slave).
interface pattern_dac_gen_if #(
  parameter int PAT_W = 32,
  parameter int DAC_W = 14,
  parameter int LEN_W = $clog2(PAT_W)
);
  logic             start;
  logic             stop;
  logic             abort;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] pat_len;
  logic             msb_first;
  logic [15:0]      bit_cycles;
  logic [15:0]      gap_cycles;
  logic [7:0]       burst_num;
  logic [DAC_W-1:0] level_hi;
  logic [DAC_W-1:0] level_lo;
  logic [DAC_W-1:0] dac_data;
  logic             pwm_out;
  logic             busy;
  logic             done;
  logic [7:0]       burst_cnt;

  modport master (
    output start, stop, abort, pat, pat_len, msb_first, bit_cycles,
           gap_cycles, burst_num, level_hi, level_lo,
    input  dac_data, pwm_out, busy, done, burst_cnt
  );

  modport slave (
    input  start, stop, abort, pat, pat_len, msb_first, bit_cycles,
           gap_cycles, burst_num, level_hi, level_lo,
    output dac_data, pwm_out, busy, done, burst_cnt
  );
endinterface

// File: rtl/pattern_dac_gen.sv
// Serialises a shadowed bit pattern onto pwm_out/dac_data in repeated bursts
// separated by a programmable gap, with graceful stop and immediate abort.
module pattern_dac_gen #(
  parameter int PAT_W = 32,
  parameter int DAC_W = 14,
  parameter int LEN_W = $clog2(PAT_W)
) (
  input logic              clk,
  input logic              rst_n,
  pattern_dac_gen_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for start, outputs at level_lo
  // ACTIVE | emitting pattern bits
  // GAP    | low output between bursts
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_s;
  logic [LEN_W-1:0] len_s;
  logic             msb_s;
  logic [15:0]      bit_cycles_s, gap_s;
  logic [7:0]       burst_num_s;
  logic [DAC_W-1:0] hi_s, lo_s;

  logic [15:0]      tmr, tmr_nx;
  logic [LEN_W-1:0] bit_idx, bit_nx;
  logic             stop_pending, pend_nx;
  logic             capture, cnt_clr, cnt_inc;
  logic [7:0]       cnt;
  logic             pwm_r, busy_r, done_r;
  logic [DAC_W-1:0] dac_r;

  logic [LEN_W:0]   len_ext;
  logic [LEN_W-1:0] len_clamped, sel;
  logic             cur_bit, last_bit, last_burst, stop_now;

  assign len_ext     = {1'b0, bus.pat_len};
  assign len_clamped = (len_ext > (LEN_W+1)'(PAT_W-1)) ? LEN_W'(PAT_W-1) : bus.pat_len;
  assign sel         = msb_s ? (len_s - bit_idx) : bit_idx;
  assign cur_bit     = |(pat_s & (PAT_W'(1) << sel));
  assign last_bit    = (bit_idx == len_s);
  // cnt still holds the pre-increment count while the final bit is on
  assign last_burst  = (burst_num_s != 8'd0) &&
                       (({1'b0, cnt} + 9'd1) == {1'b0, burst_num_s});
  assign stop_now    = stop_pending | bus.stop;

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    bit_nx   = bit_idx;
    pend_nx  = stop_pending;
    capture  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = ACTIVE;
          capture  = 1'b1;
          cnt_clr  = 1'b1;
          pend_nx  = 1'b0;
          tmr_nx   = bus.bit_cycles;
          bit_nx   = '0;
        end
      end
      ACTIVE: begin
        if (bus.stop) pend_nx = 1'b1;
        if (bus.abort) begin
          state_nx = DONE;
        end else if (tmr == 16'd0) begin
          tmr_nx = bit_cycles_s;
          if (last_bit) begin
            cnt_inc = 1'b1;
            bit_nx  = '0;
            if (last_burst || stop_now) begin
              state_nx = DONE;
            end else if (gap_s != 16'd0) begin
              state_nx = GAP;
              tmr_nx   = gap_s - 16'd1;
            end
          end else begin
            bit_nx = bit_idx + LEN_W'(1);
          end
        end else begin
          tmr_nx = tmr - 16'd1;
        end
      end
      GAP: begin
        if (bus.stop) pend_nx = 1'b1;
        if (bus.abort || stop_now) begin
          state_nx = DONE;
        end else if (tmr == 16'd0) begin
          state_nx = ACTIVE;
          tmr_nx   = bit_cycles_s;
          bit_nx   = '0;
        end else begin
          tmr_nx = tmr - 16'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        pend_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      bit_idx      <= '0;
      stop_pending <= 1'b0;
      pat_s        <= '0;
      len_s        <= '0;
      msb_s        <= 1'b0;
      bit_cycles_s <= '0;
      gap_s        <= '0;
      burst_num_s  <= '0;
      hi_s         <= '0;
      lo_s         <= '0;
      cnt          <= '0;
      pwm_r        <= 1'b0;
      dac_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state        <= state_nx;
      tmr          <= tmr_nx;
      bit_idx      <= bit_nx;
      stop_pending <= pend_nx;
      if (capture) begin
        pat_s        <= bus.pat;
        len_s        <= len_clamped;
        msb_s        <= bus.msb_first;
        bit_cycles_s <= bus.bit_cycles;
        gap_s        <= bus.gap_cycles;
        burst_num_s  <= bus.burst_num;
        hi_s         <= bus.level_hi;
        lo_s         <= bus.level_lo;
      end
      if (cnt_clr)                      cnt <= '0;
      else if (cnt_inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
      // outputs trail the state by one clock so pwm and dac move together
      pwm_r  <= (state == ACTIVE) && cur_bit;
      dac_r  <= ((state == ACTIVE) && cur_bit) ? hi_s : lo_s;
      busy_r <= (state != IDLE);
      done_r <= (state == DONE);
    end
  end

  assign bus.pwm_out   = pwm_r;
  assign bus.dac_data  = dac_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.burst_cnt = cnt;
endmodule
